// File: rtl/aes_byte_demux_collector.sv
// Collects a stream of bytes into NBYTES-wide AES blocks with valid/ready handshakes on both sides.
// Byte 0 lands in the most significant lane; a full block may hand off and accept a new byte in one cycle.
module aes_byte_demux_collector #(
    parameter int unsigned NBYTES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [7:0]                       byte_in,
    input  logic                             byte_valid,
    output logic                             byte_ready,
    output logic [8*NBYTES-1:0]              block_out,
    output logic                             block_valid,
    input  logic                             block_ready,
    output logic [$clog2(NBYTES+1)-1:0]      byte_cnt
);

    localparam int unsigned CW = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic {
        FILL,
        FULL
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [8*NBYTES-1:0] r_block;

    logic                w_byte_ready;
    logic                w_byte_xfer;
    logic                w_blk_xfer;
    logic [CW-1:0]       w_lane;

    assign w_byte_ready = ~rst & ~flush & ((r_state == FILL) | block_ready);
    assign w_byte_xfer  = byte_valid & w_byte_ready;
    assign w_blk_xfer   = (r_state == FULL) & block_ready & ~flush;
    // A byte accepted while FULL always starts the next block at lane 0.
    assign w_lane       = (r_state == FULL) ? '0 : r_cnt;

    assign byte_ready  = w_byte_ready;
    assign block_valid = (r_state == FULL);
    assign block_out   = r_block;
    assign byte_cnt    = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_block <= '0;
        end else if (flush) begin
            r_state <= FILL;
            r_cnt   <= '0;
        end else begin
            if (w_byte_xfer) begin
                for (int unsigned i = 0; i < NBYTES; i++) begin
                    if (w_lane == CW'(i)) begin
                        r_block[8*(NBYTES-1-i) +: 8] <= byte_in;
                    end
                end
            end
            case (r_state)
                FILL: begin
                    if (w_byte_xfer) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST) begin
                            r_state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (w_blk_xfer) begin
                        r_state <= FILL;
                        r_cnt   <= w_byte_xfer ? CW'(1) : '0;
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_byte_demux_collector.md
AES_BYTE_DEMUX_COLLECTOR -- requirements
Module: aes_byte_demux_collector

Interface
REQ-001: Parameter NBYTES, default 16, number of 8-bit bytes per assembled block (one AES state).
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: flush  input  1  synchronous abort; discards any partially collected block.
REQ-005: byte_in  input  8  byte from the 8-bit datapath.
REQ-006: byte_valid  input  1  byte_in carries a valid byte this cycle.
REQ-007: byte_ready  output  1  block accepts byte_in this cycle.
REQ-008: block_out  output  8*NBYTES  assembled block; byte 0 in bits [8*NBYTES-1 -: 8], byte NBYTES-1 in bits [7:0].
REQ-009: block_valid  output  1  block_out holds a complete block.
REQ-010: block_ready  input  1  consumer accepts block_out this cycle.
REQ-011: byte_cnt  output  $clog2(NBYTES+1)  bytes collected into the current block.

Function
REQ-012: The block SHALL act as a byte demultiplexer: byte_cnt selects the destination byte lane, and each accepted byte is written to lane byte_cnt of the internal block register.
REQ-013: A byte SHALL be accepted only in a cycle where byte_valid and byte_ready are both 1 ("byte transfer").
REQ-014: A block SHALL be handed off only in a cycle where block_valid and block_ready are both 1 ("block transfer").
REQ-015: The block SHALL implement two states: FILL and FULL.
REQ-016: FILL: byte_ready = 1 and block_valid = 0.
REQ-017: FILL: each byte transfer SHALL write lane byte_cnt and increment byte_cnt by 1.
REQ-018: FILL: the byte transfer at byte_cnt = NBYTES-1 SHALL set byte_cnt to NBYTES and move to FULL in the next cycle.
REQ-019: FULL: block_valid = 1 and block_out SHALL be held stable until a block transfer.
REQ-020: FULL: byte_ready = block_ready.
REQ-021: FULL with a block transfer and no byte transfer: next state FILL, byte_cnt = 0.
REQ-022: FULL with a block transfer and a byte transfer in the same cycle: the byte SHALL be written to lane 0 of the new block, byte_cnt = 1, next state FILL, with no lost cycle.
REQ-023: FULL with block_ready = 0: no byte SHALL be accepted and no state SHALL change.
REQ-024: Latency: block_valid SHALL rise in the cycle after the NBYTES-th byte transfer; minimum block period is NBYTES cycles.
REQ-025: flush = 1 SHALL force byte_ready = 0 combinationally and override every other input.
REQ-026: flush = 1: next state FILL, byte_cnt = 0, block_valid = 0 next cycle; no byte and no block transfer SHALL occur in that cycle.
REQ-027: Lanes not yet written in the current block SHALL keep their previous contents; a new block needs no clearing because all NBYTES lanes are overwritten before block_valid.
REQ-028: Writes to lanes beyond NBYTES-1 SHALL be impossible, since byte_cnt = NBYTES only in FULL.
REQ-029: byte_in and block_ready SHALL be ignored when their partner handshake signal is 0.

Reset
REQ-030: When rst = 1 at a clock edge: state = FILL, byte_cnt = 0, block_valid = 0, block_out = 0.
REQ-031: rst SHALL have priority over flush and over all handshakes.
REQ-032: Reset mid-block or in FULL SHALL discard the data; the first byte transfer after rst deasserts SHALL be written to lane 0.
REQ-033: byte_ready SHALL be 0 while rst = 1 and SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-034: After reset, send 16 consecutive bytes 0x00..0x0F with block_ready = 0 -> block_valid = 1 in the cycle after the 16th transfer, block_out = 128'h000102030405060708090A0B0C0D0E0F, and byte_ready = 0.
REQ-035: In FULL, hold block_ready = 0 for 5 cycles while byte_valid = 1 -> block_out stable, byte_cnt = 16, no byte accepted.
REQ-036: In FULL, drive block_ready = 1 and byte_valid = 1 with byte_in = 0xAA in the same cycle -> next cycle block_valid = 0, byte_cnt = 1, and lane 0 of the next block = 0xAA.
REQ-037: Accept 7 bytes, assert flush for 1 cycle with byte_valid = 1, then send 16 bytes 0x10..0x1F -> the byte in the flush cycle is not accepted and block_out = 128'h101112...1F.
REQ-038: Assert rst in FULL and again at byte_cnt = 9 -> next cycle byte_cnt = 0, block_valid = 0, block_out = 0, byte_ready = 1.
REQ-039: Random byte_valid/block_ready stalls over 100 blocks -> output block sequence equals input byte stream grouped by 16, with no loss, duplication or reordering.
